// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl
// -----------------------------------------------------------------------------
// Dynamic-reconfiguration master for the main PLL's DRP port. It takes single
// write / read / apply commands over a valid/ready handshake, drives the DRP
// strobes, holds the PLL in reset for a fixed window after reprogramming, and
// then waits for lock or a lock timeout. Every command ends with a one-cycle
// response. All logic runs on the rising edge of dclk.
//
// Ports:
//   dclk, reset           clock and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accept when both are high)
//   cmd_op                00 write, 01 read, 10 apply, 11 reserved (error)
//   cmd_addr, cmd_wdata   DRP register address and write data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    read data (0 for non-reads), timeout/reserved flag
//   pll_daddr/dcs/dwe/di  DRP strobe and data towards the PLL
//   pll_do                DRP read data from the PLL
//   pll_reset             PLL reset, active-high
//   pll_extlock           raw PLL lock, asynchronous to dclk
//   locked                synchronized lock, masked while an apply is running
// -----------------------------------------------------------------------------
module pll_drp_ctrl #(
  parameter int READ_LAT     = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       dclk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [5:0] pll_daddr,
  output logic       pll_dcs,
  output logic       pll_dwe,
  output logic [7:0] pll_di,
  input  logic [7:0] pll_do,
  output logic       pll_reset,
  input  logic       pll_extlock,
  output logic       locked
);

  typedef enum logic [2:0] {IDLE, WR, RD, RST, LOCK, RESP} state_t;

  localparam logic [3:0]  RD_LAST   = 4'(READ_LAT);
  localparam logic [7:0]  RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic        rsp_err_next;
  logic [15:0] cnt;
  logic [1:0]  lock_sync;

  // State register. Reset returns to IDLE immediately, which also drops the
  // Moore outputs (dcs, dwe, pll_reset, rsp_valid) on the same edge.
  always_ff @(posedge dclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. rsp_err_next only matters on the edge that enters RESP,
  // where it is latched into rsp_err for the whole response.
  always_comb begin
    state_next   = state;
    rsp_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00:   state_next = WR;
            2'b01:   state_next = RD;
            2'b10:   state_next = RST;
            default: begin
              state_next   = RESP;
              rsp_err_next = 1'b1;
            end
          endcase
        end
      end
      WR:   state_next = RESP;
      RD: begin
        if (cnt[3:0] == RD_LAST) begin
          state_next = RESP;
        end
      end
      RST: begin
        if (cnt[7:0] == RST_LAST) begin
          state_next = LOCK;
        end
      end
      LOCK: begin
        // Lock wins over timeout if both happen in the same cycle.
        if (lock_sync[1]) begin
          state_next = RESP;
        end else if (cnt == LOCK_LAST) begin
          state_next   = RESP;
          rsp_err_next = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: lock synchronizer, the shared cycle counter, the DRP address and
  // data registers, and the response registers. The counter restarts on every
  // state change, so each timed state starts counting from zero. DRP address
  // and data are only reloaded by commands that actually strobe the port, so
  // they keep their last driven value otherwise. Response fields are loaded
  // only on entry to RESP so they hold until the next response.
  always_ff @(posedge dclk) begin
    if (reset) begin
      lock_sync <= 2'b00;
      cnt       <= 16'd0;
      pll_daddr <= 6'd0;
      pll_di    <= 8'd0;
      rsp_rdata <= 8'd0;
      rsp_err   <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[0], pll_extlock};

      if (state != state_next) begin
        cnt <= 16'd0;
      end else if (state == RD || state == RST || state == LOCK) begin
        cnt <= cnt + 16'd1;
      end

      if (state == IDLE && cmd_valid && !cmd_op[1]) begin
        pll_daddr <= cmd_addr;
        if (!cmd_op[0]) begin
          pll_di <= cmd_wdata;
        end
      end

      if (state_next == RESP && state != RESP) begin
        rsp_rdata <= (state == RD) ? pll_do : 8'd0;
        rsp_err   <= rsp_err_next;
      end
    end
  end

  // Moore outputs. The read strobe is only the first RD cycle (counter at 0).
  // locked is masked for the whole reset/lock-wait window of an apply so the
  // requester never sees the stale lock from before reprogramming.
  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    pll_dcs   = (state == WR) || (state == RD && cnt == 16'd0);
    pll_dwe   = (state == WR);
    pll_reset = (state == RST);
    locked    = lock_sync[1] && !(state == RST || state == LOCK);
  end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb_pll_drp_ctrl
// -----------------------------------------------------------------------------
// Directed bench for pll_drp_ctrl. Instance dut uses default parameters and is
// the main target; instance dut_to uses LOCK_TIMEOUT=50 and only ever receives
// the timeout apply. A small PLL model returns 0xA5 exactly two cycles after a
// read strobe. A negedge monitor records strobes, responses and reset pulses of
// dut so each test can compare against hand-computed cycle numbers.
// -----------------------------------------------------------------------------
module tb_pll_drp_ctrl;

  logic       dclk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_valid_to = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [5:0] cmd_addr = 6'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       pll_extlock = 1'b0;
  logic [7:0] pll_do;

  logic       cmd_ready, rsp_valid, rsp_err, pll_dcs, pll_dwe, pll_reset, locked;
  logic [7:0] rsp_rdata, pll_di;
  logic [5:0] pll_daddr;

  logic       cmd_ready_to, rsp_valid_to, rsp_err_to, pll_dcs_to, pll_dwe_to;
  logic       pll_reset_to, locked_to;
  logic [7:0] rsp_rdata_to, pll_di_to;
  logic [5:0] pll_daddr_to;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pll_drp_ctrl dut (
    .dclk(dclk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pll_daddr(pll_daddr), .pll_dcs(pll_dcs), .pll_dwe(pll_dwe),
    .pll_di(pll_di), .pll_do(pll_do), .pll_reset(pll_reset),
    .pll_extlock(pll_extlock), .locked(locked)
  );

  pll_drp_ctrl #(.LOCK_TIMEOUT(50)) dut_to (
    .dclk(dclk), .reset(reset),
    .cmd_valid(cmd_valid_to), .cmd_ready(cmd_ready_to), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_to), .rsp_rdata(rsp_rdata_to), .rsp_err(rsp_err_to),
    .pll_daddr(pll_daddr_to), .pll_dcs(pll_dcs_to), .pll_dwe(pll_dwe_to),
    .pll_di(pll_di_to), .pll_do(pll_do), .pll_reset(pll_reset_to),
    .pll_extlock(pll_extlock), .locked(locked_to)
  );

  // Free-running clock and a cycle index: during cycle k (after the k-th
  // rising edge) cyc reads k.
  always #5 dclk = ~dclk;
  always @(posedge dclk) cyc <= cyc + 1;

  // PLL DRP model: read data is valid only in the cycle two after the strobe,
  // and zero otherwise, so a mistimed capture shows up as a wrong value.
  logic rd_d1 = 1'b0, rd_d2 = 1'b0;
  always @(posedge dclk) begin
    rd_d1 <= pll_dcs & ~pll_dwe;
    rd_d2 <= rd_d1;
  end
  assign pll_do = rd_d2 ? 8'hA5 : 8'h00;

  // Monitor of dut outputs, sampled mid-cycle.
  int         dcs_cnt, dcs_cyc, rsp_cnt, rsp_cyc, rst_cnt, rst_first, rst_last;
  int         early_locked, ready_rise;
  logic       dwe_seen, err_seen;
  logic       ready_prev = 1'b1;
  logic [5:0] daddr_seen;
  logic [7:0] di_seen, rdata_seen;

  always @(negedge dclk) begin
    if (pll_dcs) begin
      dcs_cnt++;
      dcs_cyc    = cyc;
      dwe_seen   = pll_dwe;
      daddr_seen = pll_daddr;
      di_seen    = pll_di;
    end
    if (locked && !rsp_valid && rsp_cnt == 0) early_locked++;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc    = cyc;
      err_seen   = rsp_err;
      rdata_seen = rsp_rdata;
    end
    if (pll_reset) begin
      rst_cnt++;
      if (rst_first < 0) rst_first = cyc;
      rst_last = cyc;
    end
    if (cmd_ready && !ready_prev) ready_rise = cyc;
    ready_prev = cmd_ready;
  end

  task automatic clearMon();
    dcs_cnt = 0; dcs_cyc = -1; rsp_cnt = 0; rsp_cyc = -1;
    rst_cnt = 0; rst_first = -1; rst_last = -1;
    early_locked = 0; ready_rise = -1;
    dwe_seen = 1'b0; err_seen = 1'b0; daddr_seen = 6'd0;
    di_seen = 8'd0; rdata_seen = 8'd0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command at a negedge; it is accepted at the following rising
  // edge (cycle t). Returns just after that edge, i.e. early in cycle t+1.
  task automatic applyStimulus(input bit sel, input logic [1:0] op,
                               input logic [5:0] addr, input logic [7:0] wdata,
                               output int t);
    @(negedge dclk);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    if (sel) begin
      checkOutput("ready_to_at_accept", 32'(cmd_ready_to), 1);
      cmd_valid_to = 1'b1;
    end else begin
      checkOutput("ready_at_accept", 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
    end
    t = cyc;
    @(posedge dclk);
    #1;
    cmd_valid    = 1'b0;
    cmd_valid_to = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    checkOutput({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    checkOutput({tag, "_rsp_err"},   32'(rsp_err),   0);
    checkOutput({tag, "_dcs"},       32'(pll_dcs),   0);
    checkOutput({tag, "_dwe"},       32'(pll_dwe),   0);
    checkOutput({tag, "_daddr"},     32'(pll_daddr), 0);
    checkOutput({tag, "_di"},        32'(pll_di),    0);
    checkOutput({tag, "_pll_reset"}, 32'(pll_reset), 0);
    checkOutput({tag, "_locked"},    32'(locked),    0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, ext_cyc, d, rsp_c, lk_to;
    bit found;
    logic err_c;

    clearMon();
    // Reset values, checked while reset is still held.
    repeat (3) @(posedge dclk);
    @(negedge dclk);
    checkResetValues("por");
    checkOutput("por_to_ready", 32'(cmd_ready_to), 1);
    checkOutput("por_to_pll_reset", 32'(pll_reset_to), 0);
    @(posedge dclk); #1;
    reset = 1'b0;
    repeat (2) @(posedge dclk); #1;

    // Write 0x3C to 0x12.
    $display("[TB] write");
    clearMon();
    applyStimulus(0, 2'b00, 6'h12, 8'h3C, t);
    repeat (6) @(posedge dclk); #1;
    checkOutput("wr_dcs_count", dcs_cnt, 1);
    checkOutput("wr_dcs_cycle", dcs_cyc, t + 1);
    checkOutput("wr_dwe",       32'(dwe_seen), 1);
    checkOutput("wr_daddr",     32'(daddr_seen), 32'h12);
    checkOutput("wr_di",        32'(di_seen), 32'h3C);
    checkOutput("wr_rsp_count", rsp_cnt, 1);
    checkOutput("wr_rsp_cycle", rsp_cyc, t + 2);
    checkOutput("wr_rsp_err",   32'(err_seen), 0);
    checkOutput("wr_rsp_rdata", 32'(rdata_seen), 0);
    checkOutput("wr_ready_back", ready_rise, t + 3);

    // Read 0x05 while a write request is held during the busy cycles.
    $display("[TB] read");
    clearMon();
    applyStimulus(0, 2'b01, 6'h05, 8'h00, t);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 6'h3F; cmd_wdata = 8'hEE;
    repeat (4) @(posedge dclk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge dclk); #1;
    checkOutput("rd_dcs_count", dcs_cnt, 1);
    checkOutput("rd_dcs_cycle", dcs_cyc, t + 1);
    checkOutput("rd_dwe",       32'(dwe_seen), 0);
    checkOutput("rd_daddr",     32'(daddr_seen), 32'h05);
    checkOutput("rd_di_held",   32'(di_seen), 32'h3C);
    checkOutput("rd_rsp_count", rsp_cnt, 1);
    checkOutput("rd_rsp_cycle", rsp_cyc, t + 4);
    checkOutput("rd_rsp_rdata", 32'(rdata_seen), 32'hA5);
    checkOutput("rd_rsp_err",   32'(err_seen), 0);
    checkOutput("rd_ready_back", ready_rise, t + 5);

    // Reserved op, with another request held in the response cycle.
    $display("[TB] reserved op");
    clearMon();
    applyStimulus(0, 2'b11, 6'h21, 8'h77, t);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    @(posedge dclk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge dclk); #1;
    checkOutput("rsv_dcs_count", dcs_cnt, 0);
    checkOutput("rsv_rsp_count", rsp_cnt, 1);
    checkOutput("rsv_rsp_cycle", rsp_cyc, t + 1);
    checkOutput("rsv_rsp_err",   32'(err_seen), 1);
    checkOutput("rsv_rsp_rdata", 32'(rdata_seen), 0);
    checkOutput("rsv_ready_back", ready_rise, t + 2);
    checkOutput("rsv_daddr_held", 32'(pll_daddr), 32'h05);

    // Apply; extlock rises 100 cycles after reset release (release at t+17).
    $display("[TB] apply with lock");
    clearMon();
    applyStimulus(0, 2'b10, 6'h00, 8'h00, t);
    repeat (116) @(posedge dclk); #1;
    pll_extlock = 1'b1;
    ext_cyc = cyc;
    repeat (10) @(posedge dclk); #1;
    d = rsp_cyc - ext_cyc;
    checkOutput("ap_extlock_cycle", ext_cyc, t + 117);
    checkOutput("ap_reset_len",   rst_cnt, 16);
    checkOutput("ap_reset_first", rst_first, t + 1);
    checkOutput("ap_reset_last",  rst_last, t + 16);
    checkOutput("ap_locked_masked", early_locked, 0);
    checkOutput("ap_rsp_count",   rsp_cnt, 1);
    checkOutput("ap_rsp_err",     32'(err_seen), 0);
    checkOutput("ap_lock_latency_2to3", 32'((d >= 2) && (d <= 3)), 1);
    @(negedge dclk);
    checkOutput("ap_locked_after", 32'(locked), 1);

    // Apply with LOCK_TIMEOUT=50 and extlock low: response at t+16+52.
    $display("[TB] apply with timeout");
    pll_extlock = 1'b0;
    repeat (5) @(posedge dclk); #1;
    applyStimulus(1, 2'b10, 6'h00, 8'h00, t);
    found = 1'b0; rsp_c = -1; err_c = 1'b0; lk_to = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge dclk);
      if (locked_to) lk_to++;
      if (rsp_valid_to) begin
        found = 1'b1;
        rsp_c = cyc;
        err_c = rsp_err_to;
      end
    end
    checkOutput("to_rsp_seen",  32'(found), 1);
    checkOutput("to_rsp_cycle", rsp_c, t + 68);
    checkOutput("to_rsp_err",   32'(err_c), 1);
    checkOutput("to_locked",    lk_to, 0);
    @(negedge dclk);
    checkOutput("to_ready_next", 32'(cmd_ready_to), 1);

    // Reset asserted in cycle t+2 of a read.
    $display("[TB] reset during read");
    clearMon();
    applyStimulus(0, 2'b01, 6'h2A, 8'h00, t);
    @(posedge dclk); #1;
    reset = 1'b1;
    @(posedge dclk); #1;
    reset = 1'b0;
    @(negedge dclk);
    checkResetValues("mid");
    repeat (6) @(posedge dclk); #1;
    checkOutput("mid_no_rsp", rsp_cnt, 0);

    // A write after the aborted read completes normally.
    $display("[TB] write after reset");
    clearMon();
    applyStimulus(0, 2'b00, 6'h07, 8'h99, t);
    repeat (6) @(posedge dclk); #1;
    checkOutput("wr2_dcs_count", dcs_cnt, 1);
    checkOutput("wr2_dcs_cycle", dcs_cyc, t + 1);
    checkOutput("wr2_dwe",       32'(dwe_seen), 1);
    checkOutput("wr2_daddr",     32'(daddr_seen), 32'h07);
    checkOutput("wr2_di",        32'(di_seen), 32'h99);
    checkOutput("wr2_rsp_cycle", rsp_cyc, t + 2);
    checkOutput("wr2_rsp_err",   32'(err_seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_drp_ctrl.md
# pll_drp_ctrl

Dynamic-reconfiguration master for the main PLL's DRP port (daddr/dcs/dwe/di/do) and its reset/extlock pins. It runs in the dclk domain. It accepts single write, read and "apply" commands from the SoC control-register side over a valid/ready handshake. It sequences the DRP strobes, holds the PLL in reset for a fixed window after reprogramming, and reports lock or a lock timeout in a one-cycle response.

## Interface
Parameters:
- READ_LAT, 2: dclk cycles from the read strobe (dcs=1, dwe=0) to valid pll_do; range 1..15.
- RST_CYCLES, 16: cycles pll_reset is held high during apply; range 1..255.
- LOCK_TIMEOUT, 65535: maximum cycles waiting for lock after reset release; 16-bit counter.

Ports:
- dclk  in  1  DRP/controller clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle; a command is accepted when cmd_valid&cmd_ready.
- cmd_op  in  2  00 write, 01 read, 10 apply, 11 reserved.
- cmd_addr  in  6  DRP register address.
- cmd_wdata  in  8  DRP write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; 0 for non-read ops.
- rsp_err  out  1  1 = lock timeout or reserved op.
- pll_daddr  out  6  to PLL daddr.
- pll_dcs  out  1  to PLL dcs.
- pll_dwe  out  1  to PLL dwe.
- pll_di  out  8  to PLL di.
- pll_do  in  8  from PLL do.
- pll_reset  out  1  to PLL reset, active-high.
- pll_extlock  in  1  from PLL extlock; asynchronous to dclk.
- locked  out  1  synchronized lock status.

## Operation
- States: IDLE, WR, RD, RST, LOCK, RESP.
- IDLE: cmd_ready=1. On accept, cmd_addr, cmd_wdata and cmd_op are captured. Next state is WR (00), RD (01), RST (10) or RESP with err=1 (11).
- WR: pll_dcs=1, pll_dwe=1, pll_daddr/pll_di = captured values for exactly one cycle, then RESP.
- RD: pll_dcs=1, pll_dwe=0 in the first RD cycle only. A 4-bit counter counts READ_LAT cycles, then pll_do is captured into rsp_rdata and the FSM goes to RESP.
- RST: pll_reset=1 for RST_CYCLES cycles, then LOCK with the timeout counter cleared.
- LOCK: wait for the synchronized lock to go high, then RESP with err=0. If the counter reaches LOCK_TIMEOUT first, go to RESP with err=1.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- pll_extlock passes through a 2-flop synchronizer. locked = synchronized value, forced 0 from an apply accept until that apply's RESP cycle.
- pll_dcs/pll_dwe are 0 in every state except the strobe cycle. pll_daddr/pll_di hold their last value.
- Commands presented while cmd_ready=0 are ignored. The requester holds its fields until accepted.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, pll_dcs=0, pll_dwe=0, pll_daddr=0, pll_di=0, pll_reset=0, locked=0, FSM=IDLE, synchronizer=0.
- Accept in cycle T (all ops). Timings below are relative to T.
- Write: strobe at T+1, rsp_valid at T+2, cmd_ready at T+3.
- Read: strobe at T+1. pll_do is sampled at the edge ending cycle T+1+READ_LAT. rsp_valid at T+2+READ_LAT (T+4 for default).
- Reserved op: no strobe, rsp_valid with rsp_err=1 at T+1.
- Apply: pll_reset high from T+1 through T+RST_CYCLES. Lock wait starts at T+RST_CYCLES+1.
  - If synchronized lock is high at LOCK entry, rsp_valid is at T+RST_CYCLES+2.
  - Lock sync latency is 2 cycles.
  - On timeout, rsp_valid (err=1) is at T+RST_CYCLES+1+LOCK_TIMEOUT+1.
- rsp_rdata and rsp_err are valid only during rsp_valid and hold until the next response.
- Reset mid-operation: at the next edge all outputs take their reset values, including pll_reset=0 and pll_dcs=0. No response is issued for the aborted command.
- Lock dropping during LOCK after being seen high has no effect, because the FSM has already left LOCK.

## Test plan
- Write addr=0x12, wdata=0x3C: pll_dcs=pll_dwe=1, daddr=0x12, di=0x3C for exactly one cycle at T+1; rsp_valid at T+2 with err=0 and rdata=0.
- Read addr=0x05, READ_LAT=2, PLL model drives do=0xA5 two cycles after dcs: single strobe with dwe=0; rsp_valid at T+4 with rdata=0xA5.
- Apply, RST_CYCLES=16, extlock rises 100 cycles after reset release:
  - pll_reset is high for exactly 16 cycles;
  - locked stays 0 throughout;
  - rsp_valid with err=0 arrives 2–3 cycles after extlock rises;
  - locked=1 afterwards.
- Apply with LOCK_TIMEOUT=50 and extlock held 0: rsp_err=1 at T+16+52; locked=0; cmd_ready=1 next cycle.
- Reset asserted at T+2 of a read: no rsp_valid; all outputs at reset values the next cycle; a following write completes normally.
- cmd_op=11: no DRP strobe; rsp_valid with rsp_err=1 at T+1; back-to-back cmd_valid during busy cycles is not accepted.
